// File: rtl/digtal_tx_framer_if.sv
// Host-side bus of the Digtal transmit framer: byte write strobe, frame start and status.
interface digtal_tx_framer_if;
    logic       WR_Digtal;
    logic [7:0] Data_In;
    logic       Send;
    logic       Tx_Digtal;
    logic       Busy;
    logic       Full;
    logic       Empty;
    logic       Overflow;

    modport master (
        output WR_Digtal, Data_In, Send,
        input  Tx_Digtal, Busy, Full, Empty, Overflow
    );

    modport slave (
        input  WR_Digtal, Data_In, Send,
        output Tx_Digtal, Busy, Full, Empty, Overflow
    );
endinterface

// File: rtl/digtal_tx_framer.sv
// Digtal serial transmit framer: payload FIFO, sync header, 8N1 LSB-first serialiser.
// Optional feature macro DIGTAL_TX_CHECKSUM_EN appends a mod-256 payload sum after the payload.
module digtal_tx_framer #(
    parameter int unsigned CLOCK_Frequency = 29491200,
    parameter int unsigned BAUD_Digtal     = 921600,
    parameter int unsigned FIFO_AW         = 11,
    parameter int unsigned Instert_Length  = 4,
    parameter logic [7:0]  Instert_Byte1   = 8'hEB,
    parameter logic [7:0]  Instert_Byte2   = 8'h90,
    parameter logic [7:0]  Instert_Byte3   = 8'h90,
    parameter logic [7:0]  Instert_Byte4   = 8'hEB,
    parameter logic [7:0]  Instert_Byte5   = 8'hEB,
    parameter logic [7:0]  Instert_Byte6   = 8'h90,
    parameter logic [7:0]  Instert_Byte7   = 8'h90,
    parameter logic [7:0]  Instert_Byte8   = 8'hEB
) (
    input logic               Clock_29491200Hz,
    input logic               Reset_n,
    digtal_tx_framer_if.slave bus
);

    localparam int unsigned BaudDiv = CLOCK_Frequency / (BAUD_Digtal * 16);
    localparam int unsigned DivW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
    localparam int unsigned Depth   = 2 ** FIFO_AW;
    localparam int unsigned PtrW    = FIFO_AW + 1;
    localparam logic [PtrW-1:0] PtrFull = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
`ifdef DIGTAL_TX_CHECKSUM_EN
        StCsum,
`endif
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [DivW-1:0] div_q;
    logic            baud_tick;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            full_q, empty_q, overflow_q;
    logic            push, pop;
    logic [7:0]      mem [Depth];
    logic [7:0]      fifo_rdata;

    logic [3:0]      hdr_idx_q, hdr_idx_d;
    logic            hdr_done;
    logic [7:0]      hdr_byte;

    logic            active_q, tx_q;
    logic [8:0]      shift_q;
    logic [3:0]      bit_cnt_q, tick_cnt_q;
    logic            byte_end, slot, load;
    logic [7:0]      load_byte;
    logic            busy;

`ifdef DIGTAL_TX_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    // Free-running divider producing the 16x baud tick.
    always_ff @(posedge Clock_29491200Hz or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q <= '0;
        end else if (baud_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    assign baud_tick = (div_q == DivW'(BaudDiv - 1));

    // FIFO pointers and registered status flags.
    assign push     = bus.WR_Digtal && !full_q;
    assign wr_ptr_d = wr_ptr_q + PtrW'(push);
    assign rd_ptr_d = rd_ptr_q + PtrW'(pop);

    always_ff @(posedge Clock_29491200Hz or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= ((wr_ptr_d - rd_ptr_d) == PtrFull);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
            if (bus.WR_Digtal && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge Clock_29491200Hz) begin
        if (push) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= bus.Data_In;
        end
    end

    assign fifo_rdata = mem[rd_ptr_q[FIFO_AW-1:0]];

    // Header byte selection by index.
    always_comb begin
        hdr_byte = Instert_Byte1;
        case (hdr_idx_q)
            4'd0:    hdr_byte = Instert_Byte1;
            4'd1:    hdr_byte = Instert_Byte2;
            4'd2:    hdr_byte = Instert_Byte3;
            4'd3:    hdr_byte = Instert_Byte4;
            4'd4:    hdr_byte = Instert_Byte5;
            4'd5:    hdr_byte = Instert_Byte6;
            4'd6:    hdr_byte = Instert_Byte7;
            4'd7:    hdr_byte = Instert_Byte8;
            default: hdr_byte = Instert_Byte1;
        endcase
    end

    // A byte slot opens on a tick when the shifter is idle or its stop bit just completed.
    assign byte_end = active_q && (bit_cnt_q == 4'd9) && (tick_cnt_q == 4'd15);
    assign slot     = baud_tick && (!active_q || byte_end);
    assign hdr_done = (hdr_idx_q == 4'(Instert_Length));

    // FSM state register (plus header index and checksum accumulator).
    always_ff @(posedge Clock_29491200Hz or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            hdr_idx_q <= '0;
`ifdef DIGTAL_TX_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
`ifdef DIGTAL_TX_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // FSM next state: decides at each byte slot what, if anything, is serialised next.
    always_comb begin
        state_d   = state_q;
        hdr_idx_d = hdr_idx_q;
        pop       = 1'b0;
        load      = 1'b0;
        load_byte = 8'h00;
`ifdef DIGTAL_TX_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.Send) begin
                    state_d   = StHdr;
                    hdr_idx_d = '0;
`ifdef DIGTAL_TX_CHECKSUM_EN
                    csum_d    = '0;
`endif
                end
            end
            StHdr, StData: begin
                if (slot) begin
                    if ((state_q == StHdr) && !hdr_done) begin
                        load      = 1'b1;
                        load_byte = hdr_byte;
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end else if (!empty_q) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        load_byte = fifo_rdata;
                        state_d   = StData;
`ifdef DIGTAL_TX_CHECKSUM_EN
                        csum_d    = csum_q + fifo_rdata;
`endif
                    end else begin
`ifdef DIGTAL_TX_CHECKSUM_EN
                        load      = 1'b1;
                        load_byte = csum_q;
                        state_d   = StCsum;
`else
                        state_d   = StDone;
`endif
                    end
                end
            end
`ifdef DIGTAL_TX_CHECKSUM_EN
            StCsum: begin
                if (slot) begin
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: busy covers every state that owns the line.
    always_comb begin
        busy = !((state_q == StIdle) || (state_q == StDone));
    end

    // Byte shifter: start bit, d0..d7, stop bit, each held for 16 baud ticks.
    always_ff @(posedge Clock_29491200Hz or negedge Reset_n) begin
        if (!Reset_n) begin
            active_q   <= 1'b0;
            tx_q       <= 1'b1;
            shift_q    <= '1;
            bit_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else if (load) begin
            active_q   <= 1'b1;
            tx_q       <= 1'b0;
            shift_q    <= {1'b1, load_byte};
            bit_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else if (baud_tick && active_q) begin
            if (byte_end) begin
                active_q <= 1'b0;
                tx_q     <= 1'b1;
            end else begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd15) begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    tx_q      <= shift_q[0];
                    shift_q   <= {1'b1, shift_q[8:1]};
                end
            end
        end
    end

    assign bus.Tx_Digtal = tx_q;
    assign bus.Busy      = busy;
    assign bus.Full      = full_q;
    assign bus.Empty     = empty_q;
    assign bus.Overflow  = overflow_q;

endmodule
